// File: rtl/interrupt_arbiter.sv
// Interrupt gateway plus round-robin claim/complete arbiter: masked level requests latch
// as pending, the core claims one source ID at a time and releases it on completion.
module interrupt_arbiter #(
  parameter int N_interrupts = 32,
  parameter int ID_W         = $clog2(N_interrupts + 1)
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [N_interrupts-1:0] interrupt_requests_masked,
  input  logic                    claim_req,
  input  logic                    complete_req,
  input  logic [ID_W-1:0]         complete_id,
  output logic                    interrupt_out,
  output logic                    claim_valid,
  output logic [ID_W-1:0]         claim_id,
  output logic [N_interrupts-1:0] pending,
  output logic [N_interrupts-1:0] in_service
);

  localparam int N     = N_interrupts;
  localparam int PTR_W = $clog2(N_interrupts);
  localparam logic [PTR_W:0]   L_N    = (PTR_W + 1)'(N_interrupts);
  localparam logic [PTR_W-1:0] L_LAST = PTR_W'(N_interrupts - 1);
  localparam logic [ID_W-1:0]  L_NID  = ID_W'(N_interrupts);

  logic [N-1:0]     r_pending;
  logic [N-1:0]     r_inService;
  logic [PTR_W-1:0] r_rrPtr;
  logic             r_claimValid;
  logic [ID_W-1:0]  r_claimId;
  logic             r_intOut;

  logic [N-1:0]     w_rot;
  logic             w_found;
  logic [PTR_W-1:0] w_pos;
  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_ptrNext;
  logic [ID_W-1:0]  w_winId;
  logic [ID_W-1:0]  w_cidx;
  logic             w_cidOk;
  logic [N-1:0]     w_claimMask;
  logic [N-1:0]     w_clrMask;
  logic [N-1:0]     w_pendNext;
  logic [N-1:0]     w_isNext;

  // Rotate pending so that index rr_ptr sits at bit 0; the lowest set bit is then the winner.
  assign w_rot = N'({r_pending, r_pending} >> r_rrPtr);

  always_comb begin
    w_found = 1'b0;
    w_pos   = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_found = 1'b1;
        w_pos   = PTR_W'(j);
      end
    end
  end

  assign w_sum     = {1'b0, r_rrPtr} + {1'b0, w_pos};
  assign w_win     = (w_sum >= L_N) ? PTR_W'(w_sum - L_N) : w_sum[PTR_W-1:0];
  assign w_ptrNext = (w_win == L_LAST) ? '0 : w_win + PTR_W'(1);
  assign w_winId   = ID_W'(w_win) + ID_W'(1);

  assign w_cidOk     = complete_req && (complete_id != '0) && (complete_id <= L_NID);
  assign w_cidx      = complete_id - ID_W'(1);
  assign w_clrMask   = w_cidOk ? (N'(1) << w_cidx) : '0;
  assign w_claimMask = (claim_req && w_found) ? (N'(1) << w_win) : '0;

  // Gateway uses the registered in_service, so a completed source re-pends one edge later.
  assign w_pendNext = (r_pending | (interrupt_requests_masked & ~r_pending & ~r_inService))
                      & ~w_claimMask;
  assign w_isNext   = (r_inService & ~w_clrMask) | w_claimMask;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pending    <= '0;
      r_inService  <= '0;
      r_rrPtr      <= '0;
      r_claimValid <= 1'b0;
      r_claimId    <= '0;
      r_intOut     <= 1'b0;
    end else begin
      r_pending    <= w_pendNext;
      r_inService  <= w_isNext;
      r_intOut     <= |w_pendNext;
      r_claimValid <= claim_req;
      if (claim_req) begin
        r_claimId <= w_found ? w_winId : '0;
        if (w_found) begin
          r_rrPtr <= w_ptrNext;
        end
      end
    end
  end

  assign pending       = r_pending;
  assign in_service    = r_inService;
  assign claim_valid   = r_claimValid;
  assign claim_id      = r_claimId;
  assign interrupt_out = r_intOut;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench for interrupt_arbiter: a behavioural model predicts state and claim IDs,
// a separate monitor pops expected IDs whenever claim_valid pulses.
module tb_interrupt_arbiter;

  localparam int N    = 32;
  localparam int ID_W = $clog2(N + 1);

  logic             CLK = 1'b0;
  logic             nRST = 1'b1;
  logic [N-1:0]     reqs = '0;
  logic             claimReq = 1'b0;
  logic             completeReq = 1'b0;
  logic [ID_W-1:0]  completeId = '0;
  logic             interruptOut;
  logic             claimValid;
  logic [ID_W-1:0]  claimId;
  logic [N-1:0]     pendingVec;
  logic [N-1:0]     inServiceVec;

  int nChecks = 0;
  int nPass   = 0;
  int expQ[$];

  bit mPend[N];
  bit mServ[N];
  int mPtr;
  int mLastId;

  interrupt_arbiter #(.N_interrupts(N)) dut (
    .CLK                       (CLK),
    .nRST                      (nRST),
    .interrupt_requests_masked (reqs),
    .claim_req                 (claimReq),
    .complete_req              (completeReq),
    .complete_id               (completeId),
    .interrupt_out             (interruptOut),
    .claim_valid               (claimValid),
    .claim_id                  (claimId),
    .pending                   (pendingVec),
    .in_service                (inServiceVec)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [63:0] packBits(input bit b[N]);
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = b[i];
    return v;
  endfunction

  function automatic bit anyPending();
    for (int i = 0; i < N; i++) if (mPend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      mPend[i] = 1'b0;
      mServ[i] = 1'b0;
    end
    mPtr    = 0;
    mLastId = 0;
  endtask

  // One clock edge of behaviour: pick the winner from the old pending set, then apply
  // the gateway, completion and claim effects.
  task automatic modelStep(input logic [N-1:0] req, input bit clm, input bit cmp, input int cid);
    int win = -1;
    for (int off = 0; off < N; off++) begin
      int k = (mPtr + off) % N;
      if (mPend[k]) begin
        win = k;
        break;
      end
    end
    for (int i = 0; i < N; i++)
      if (req[i] && !mPend[i] && !mServ[i]) mPend[i] = 1'b1;
    if (cmp && cid >= 1 && cid <= N) mServ[cid-1] = 1'b0;
    if (clm) begin
      if (win >= 0) begin
        mPend[win] = 1'b0;
        mServ[win] = 1'b1;
        mPtr       = (win + 1) % N;
        mLastId    = win + 1;
      end else begin
        mLastId = 0;
      end
      expQ.push_back(mLastId);
    end
  endtask

  // Called at a falling edge; drives one cycle of inputs and returns at the next falling edge.
  task automatic applyStimulus(input logic [N-1:0] req, input bit clm, input bit cmp, input int cid);
    reqs        = req;
    claimReq    = clm;
    completeReq = cmp;
    completeId  = ID_W'(cid);
    modelStep(req, clm, cmp, cid % (1 << ID_W));
    @(posedge CLK);
    #1;
    checkOutput("pending", pendingVec, packBits(mPend));
    checkOutput("inService", inServiceVec, packBits(mServ));
    checkOutput("interruptOut", interruptOut, anyPending());
    checkOutput("claimIdHeld", claimId, mLastId);
    @(negedge CLK);
    claimReq    = 1'b0;
    completeReq = 1'b0;
  endtask

  task automatic resetDut(input logic [N-1:0] holdReq);
    nRST        = 1'b0;
    reqs        = holdReq;
    claimReq    = 1'b1;
    completeReq = 1'b0;
    completeId  = '0;
    #1;
    expQ.delete();
    modelReset();
    for (int c = 0; c < 3; c++) begin
      checkOutput("rstPending", pendingVec, 0);
      checkOutput("rstInService", inServiceVec, 0);
      checkOutput("rstClaimValid", claimValid, 0);
      checkOutput("rstClaimId", claimId, 0);
      checkOutput("rstInterruptOut", interruptOut, 0);
      @(negedge CLK);
    end
    claimReq = 1'b0;
    nRST     = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (nRST && claimValid) begin
        if (expQ.size() == 0) checkOutput("claimValidUnexpected", claimValid, 0);
        else checkOutput("claimId", claimId, expQ.pop_front());
      end
    end
  end

  initial begin : driver
    logic [N-1:0] r;
    #1;
    @(negedge CLK);
    resetDut('1);
    applyStimulus('1, 0, 0, 0);
    applyStimulus('0, 0, 0, 0);
    @(negedge CLK);
    resetDut('0);

    // Single source 5: claim, no re-pend while in service, re-pend after complete
    for (int c = 0; c < 2; c++) applyStimulus(N'(1) << 5, 0, 0, 0);
    applyStimulus(N'(1) << 5, 1, 0, 0);
    for (int c = 0; c < 2; c++) applyStimulus(N'(1) << 5, 0, 0, 0);
    applyStimulus(N'(1) << 5, 0, 1, 6);
    applyStimulus(N'(1) << 5, 0, 0, 0);
    applyStimulus('0, 1, 0, 0);
    applyStimulus('0, 0, 1, 6);

    // Empty claims, back to back
    applyStimulus('0, 1, 0, 0);
    applyStimulus('0, 1, 0, 0);

    // Round-robin over sources 2, 7, 30, then wrap
    applyStimulus((N'(1) << 2) | (N'(1) << 7) | (N'(1) << 30), 0, 0, 0);
    for (int c = 0; c < 3; c++) applyStimulus('0, 1, 0, 0);
    applyStimulus('0, 0, 1, 3);
    applyStimulus('0, 0, 1, 8);
    applyStimulus((N'(1) << 2) | (N'(1) << 7), 0, 0, 0);
    applyStimulus('0, 1, 0, 0);
    applyStimulus('0, 1, 0, 0);
    applyStimulus('0, 0, 1, 3);
    applyStimulus(N'(1) << 2, 0, 0, 0);
    applyStimulus('0, 1, 0, 0);

    // Simultaneous claim of 7 with completion of ID 3
    applyStimulus('0, 0, 1, 8);
    applyStimulus(N'(1) << 7, 0, 0, 0);
    applyStimulus('0, 1, 1, 3);

    // Ignored completes
    applyStimulus('0, 0, 1, 0);
    applyStimulus('0, 0, 1, 33);
    applyStimulus('0, 0, 1, 6);
    applyStimulus('0, 0, 1, 63);

    for (int c = 0; c < 400; c++) begin
      if (c == 200) resetDut($urandom);
      r = N'($urandom & $urandom & $urandom);
      applyStimulus(r, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 9) == 0) ? 63 : $urandom_range(0, N + 2));
    end

    applyStimulus('0, 0, 0, 0);
    applyStimulus('0, 0, 0, 0);
    checkOutput("claimQueueDrained", expQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
